lsu_coalescer: RTL and testbench

- First stage of the LSU. Consumes the registered warp-wide load/store packet from the execute-to-LSU pipeline register.
- Groups the active lanes by cache-line address and issues one memory request per distinct line over a valid/ready interface.
- Holds the upstream register through a stall signal until every active lane has been issued.

---
 rtl/lsu_coalescer_pkg.sv | 18 +
 rtl/lsu_lane_pick.sv | 15 +
 rtl/lsu_coalescer.sv | 110 +++++++++++
 tb/tb_lsu_coalescer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_coalescer_pkg.sv
// lsu_coalescer_pkg: shared LSU widths, lane-packet field offsets and coalescer state encoding
package lsu_coalescer_pkg;
  localparam int SIZE_CORE       = 32;
  localparam int SIZE_ADDR       = 32;
  localparam int SIZE_REGFILE_BR = 8;
  localparam int SIZE_DATA       = 32;
  localparam int LDST_SPACE_LOG  = 2;
  localparam int LDST_TYPES_LOG  = 2;
  localparam int NUM_WARP_LOG    = 3;
  localparam int PKT_W           = 32 + SIZE_REGFILE_BR + SIZE_DATA + LDST_SPACE_LOG + LDST_TYPES_LOG;
  localparam int LINE_LOG        = 6;
  localparam int TYPE_LSB        = 0;
  localparam int SPACE_LSB       = TYPE_LSB + LDST_TYPES_LOG;
  localparam int REG_LSB         = SPACE_LSB + LDST_SPACE_LOG;
  localparam int DATA_LSB        = REG_LSB + SIZE_REGFILE_BR;
  localparam int ADDR_LSB        = PKT_W - SIZE_ADDR;
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;
endpackage

// File: rtl/lsu_lane_pick.sv
// lsu_lane_pick: lowest-set-bit priority encoder; vec_i lanes in, idx_o lowest set lane, found_o any set
module lsu_lane_pick #(
  parameter int N = 32,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) if (vec_i[i]) idx_o = IW'(i);
  end
  assign found_o = |vec_i;
endmodule

// File: rtl/lsu_coalescer.sv
// lsu_coalescer: captures a warp load/store packet and issues one request per distinct cache line
// ports: ldst*_i upstream packet, stall_o holds upstream; req_* valid/ready line requests;
//        packets_o captured lanes; done_o/done_warp_o completion pulse
module lsu_coalescer
  import lsu_coalescer_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_i,
  input  logic                         store_i,
  input  logic [LDST_SPACE_LOG-1:0]    ldstSpace_i,
  input  logic [NUM_WARP_LOG-1:0]      ldstWarp_i,
  input  logic                         ldstPacketValid_i,
  input  logic [SIZE_CORE-1:0]         ldstMask_i,
  input  logic [SIZE_CORE*PKT_W-1:0]   ldstPackets_i,
  output logic                         stall_o,
  output logic                         req_valid_o,
  input  logic                         req_ready_i,
  output logic                         req_load_o,
  output logic                         req_store_o,
  output logic [LDST_SPACE_LOG-1:0]    req_space_o,
  output logic [NUM_WARP_LOG-1:0]      req_warp_o,
  output logic [SIZE_ADDR-LINE_LOG-1:0] req_line_o,
  output logic [SIZE_CORE-1:0]         req_mask_o,
  output logic [SIZE_CORE*PKT_W-1:0]   packets_o,
  output logic                         done_o,
  output logic [NUM_WARP_LOG-1:0]      done_warp_o
);
  localparam int LW = SIZE_ADDR - LINE_LOG;
  localparam int IW = $clog2(SIZE_CORE);
  state_e                     state_q, state_d;
  logic [SIZE_CORE-1:0]       pending_q, pending_d, match;
  logic [SIZE_CORE*PKT_W-1:0] pkts_q, pkts_d;
  logic [NUM_WARP_LOG-1:0]    warp_q, warp_d, done_warp_q, done_warp_d;
  logic [LDST_SPACE_LOG-1:0]  space_q, space_d;
  logic                       load_q, load_d, store_q, store_d, done_q, done_d;
  logic [LW-1:0]              line [SIZE_CORE];
  logic [IW-1:0]              lead;
  logic                       found, busy, cap;
  lsu_lane_pick #(.N(SIZE_CORE)) u_pick (.vec_i(pending_q), .idx_o(lead), .found_o(found));
  for (genvar i = 0; i < SIZE_CORE; i++) begin : g_lane
    assign line[i]  = pkts_q[i*PKT_W+ADDR_LSB+LINE_LOG +: LW];
    assign match[i] = pending_q[i] & (line[i] == req_line_o);
  end
  assign busy        = state_q == ISSUE;
  assign cap         = ldstPacketValid_i & (load_i | store_i);
  assign stall_o     = busy;
  assign req_valid_o = busy & found;
  assign req_line_o  = busy ? line[lead] : '0;
  assign req_mask_o  = match;
  assign req_load_o  = load_q;
  assign req_store_o = store_q;
  assign req_space_o = space_q;
  assign req_warp_o  = warp_q;
  assign packets_o   = pkts_q;
  assign done_o      = done_q;
  assign done_warp_o = done_warp_q;
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    pkts_d      = pkts_q;
    warp_d      = warp_q;
    space_d     = space_q;
    load_d      = load_q;
    store_d     = store_q;
    done_d      = 1'b0;
    done_warp_d = done_warp_q;
    if (state_q == IDLE) begin
      if (cap) begin
        pkts_d      = ldstPackets_i;
        warp_d      = ldstWarp_i;
        space_d     = ldstSpace_i;
        load_d      = load_i;
        store_d     = store_i & ~load_i;
        pending_d   = ldstMask_i;
        state_d     = (|ldstMask_i) ? ISSUE : IDLE;
        done_d      = ~|ldstMask_i;
        done_warp_d = ldstWarp_i;
      end
    end else if (req_valid_o && req_ready_i) begin
      pending_d   = pending_q & ~match;
      state_d     = (|pending_d) ? ISSUE : IDLE;
      done_d      = ~|pending_d;
      done_warp_d = warp_q;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      pkts_q      <= '0;
      warp_q      <= '0;
      space_q     <= '0;
      load_q      <= 1'b0;
      store_q     <= 1'b0;
      done_q      <= 1'b0;
      done_warp_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      pkts_q      <= pkts_d;
      warp_q      <= warp_d;
      space_q     <= space_d;
      load_q      <= load_d;
      store_q     <= store_d;
      done_q      <= done_d;
      done_warp_q <= done_warp_d;
    end
  end
endmodule

// File: tb/tb_lsu_coalescer.sv
// tb_lsu_coalescer: randomized and directed self-checking bench for lsu_coalescer
module tb_lsu_coalescer;
  import lsu_coalescer_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic load_i, store_i, ldstPacketValid_i, req_ready_i;
  logic [LDST_SPACE_LOG-1:0] ldstSpace_i;
  logic [NUM_WARP_LOG-1:0] ldstWarp_i;
  logic [SIZE_CORE-1:0] ldstMask_i;
  logic [SIZE_CORE*PKT_W-1:0] ldstPackets_i;
  logic stall_o, req_valid_o, req_load_o, req_store_o, done_o;
  logic [LDST_SPACE_LOG-1:0] req_space_o;
  logic [NUM_WARP_LOG-1:0] req_warp_o, done_warp_o;
  logic [SIZE_ADDR-LINE_LOG-1:0] req_line_o;
  logic [SIZE_CORE-1:0] req_mask_o;
  logic [SIZE_CORE*PKT_W-1:0] packets_o;
  int checks = 0, errors = 0;
  logic [31:0] addr [SIZE_CORE];
  logic [SIZE_CORE*PKT_W-1:0] bus;
  logic [31:0] exp_line[$], exp_mask[$], got_line[$], got_mask[$];
  int n_stall, done_cyc, first_valid, hold_viol;
  logic got_done, got_load, got_store;
  logic [NUM_WARP_LOG-1:0] got_dwarp, got_warp;
  logic [LDST_SPACE_LOG-1:0] got_space;
  logic [SIZE_CORE*PKT_W-1:0] got_pkts;
  always #5 clk = ~clk;
  lsu_coalescer dut (
    .clk(clk), .reset(reset), .load_i(load_i), .store_i(store_i), .ldstSpace_i(ldstSpace_i),
    .ldstWarp_i(ldstWarp_i), .ldstPacketValid_i(ldstPacketValid_i), .ldstMask_i(ldstMask_i),
    .ldstPackets_i(ldstPackets_i), .stall_o(stall_o), .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i), .req_load_o(req_load_o), .req_store_o(req_store_o),
    .req_space_o(req_space_o), .req_warp_o(req_warp_o), .req_line_o(req_line_o),
    .req_mask_o(req_mask_o), .packets_o(packets_o), .done_o(done_o), .done_warp_o(done_warp_o)
  );
  function automatic void build_model(input logic [31:0] m);
    logic [31:0] pend, mk, ln;
    int ld;
    exp_line.delete();
    exp_mask.delete();
    pend = m;
    while (pend != 0) begin
      ld = 0;
      while (!pend[ld]) ld++;
      ln = addr[ld] / 64;
      mk = 0;
      for (int i = 0; i < SIZE_CORE; i++) if (pend[i] && addr[i] / 64 == ln) mk[i] = 1'b1;
      exp_line.push_back(ln);
      exp_mask.push_back(mk);
      pend = pend & ~mk;
    end
  endfunction
  task automatic drive(input logic [31:0] m, input logic ld, input logic st,
                       input logic [NUM_WARP_LOG-1:0] w, input logic [LDST_SPACE_LOG-1:0] sp);
    logic [PKT_W-SIZE_ADDR-1:0] lo;
    for (int i = 0; i < SIZE_CORE; i++) begin
      lo = (PKT_W-SIZE_ADDR)'({$urandom(), $urandom()});
      bus[i*PKT_W +: PKT_W] = {addr[i], lo};
    end
    ldstPackets_i = bus;
    ldstMask_i = m;
    load_i = ld;
    store_i = st;
    ldstWarp_i = w;
    ldstSpace_i = sp;
    ldstPacketValid_i = 1'b1;
    @(posedge clk);
    #1;
    ldstPacketValid_i = 1'b0;
    load_i = 1'b0;
    store_i = 1'b0;
    ldstMask_i = $urandom();
  endtask
  task automatic collect(input int mode, input int hold, input int budget);
    logic rdy, pv;
    logic [31:0] pl, pm;
    got_line.delete();
    got_mask.delete();
    n_stall = 0;
    got_done = 1'b0;
    first_valid = -1;
    hold_viol = 0;
    done_cyc = -1;
    pv = 1'b0;
    pl = 0;
    pm = 0;
    for (int c = 0; c < budget && !got_done; c++) begin
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (c >= hold) : 1'($urandom_range(0, 1));
      req_ready_i = rdy;
      if (stall_o) n_stall++;
      if (pv && req_valid_o && (32'(req_line_o) !== pl || req_mask_o !== pm)) hold_viol++;
      if (req_valid_o && first_valid < 0) begin
        first_valid = c;
        got_load = req_load_o;
        got_store = req_store_o;
        got_warp = req_warp_o;
        got_space = req_space_o;
        got_pkts = packets_o;
      end
      if (req_valid_o && rdy) begin
        got_line.push_back(32'(req_line_o));
        got_mask.push_back(req_mask_o);
        pv = 1'b0;
      end else begin
        pv = req_valid_o;
        pl = 32'(req_line_o);
        pm = req_mask_o;
      end
      if (done_o) begin
        got_done = 1'b1;
        done_cyc = c;
        got_dwarp = done_warp_o;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    load_i = 0; store_i = 0; ldstPacketValid_i = 0; req_ready_i = 0;
    ldstSpace_i = 0; ldstWarp_i = 0; ldstMask_i = 0; ldstPackets_i = 0;
    #23;
    checks++;
    if ({stall_o, req_valid_o, done_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000", {stall_o, req_valid_o, done_o});
    end
    checks++;
    if (packets_o !== '0 || req_mask_o !== '0 || req_line_o !== '0 || done_warp_o !== '0) begin
      errors++;
      $display("FAIL reset_data: mask %h line %h warp %h expected all 0", req_mask_o, req_line_o, done_warp_o);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic test_full_warp();
    for (int i = 0; i < SIZE_CORE; i++) addr[i] = 32'h1000 + 4 * i;
    drive(32'hFFFF_FFFF, 1'b1, 1'b0, 3'd5, 2'd1);
    collect(0, 0, 20);
    checks++;
    if (got_line.size() != 2 || got_line[0] !== 32'h40 || got_mask[0] !== 32'h0000_FFFF ||
        got_line[1] !== 32'h41 || got_mask[1] !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL full_reqs: got n=%0d %h/%h %h/%h expected 40/0000ffff 41/ffff0000",
               got_line.size(), got_line[0], got_mask[0], got_line[1], got_mask[1]);
    end
    checks++;
    if (!got_done || done_cyc != 2 || n_stall != 2 || first_valid != 0) begin
      errors++;
      $display("FAIL full_timing: done %b at %0d stall %0d first %0d expected 1 at 2 stall 2 first 0",
               got_done, done_cyc, n_stall, first_valid);
    end
    checks++;
    if ({got_load, got_store, got_space, got_warp, got_dwarp} !== {1'b1, 1'b0, 2'd1, 3'd5, 3'd5}) begin
      errors++;
      $display("FAIL full_attr: got ld %b st %b sp %0d w %0d dw %0d expected 1 0 1 5 5",
               got_load, got_store, got_space, got_warp, got_dwarp);
    end
    checks++;
    if (got_pkts !== bus) begin
      errors++;
      $display("FAIL full_packets: got %h expected %h", got_pkts[63:0], bus[63:0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got %b expected 0", done_o);
    end
  endtask
  task automatic test_stride();
    for (int i = 0; i < SIZE_CORE; i++) addr[i] = 64 * i;
    drive(32'hF, 1'b0, 1'b1, 3'd2, 2'd3);
    collect(0, 0, 20);
    checks++;
    if (got_line.size() != 4) begin
      errors++;
      $display("FAIL stride_count: got %0d expected 4", got_line.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_line[k] !== 32'(k) || got_mask[k] !== 32'(1 << k)) begin
        errors++;
        $display("FAIL stride_req%0d: got %h/%h expected %h/%h", k, got_line[k], got_mask[k], k, 1 << k);
      end
    end
    checks++;
    if (!got_done || done_cyc != 4 || got_store !== 1'b1 || got_load !== 1'b0) begin
      errors++;
      $display("FAIL stride_done: done %b at %0d st %b ld %b expected 1 at 4 st 1 ld 0", got_done, done_cyc, got_store, got_load);
    end
  endtask
  task automatic test_backpressure();
    for (int i = 0; i < SIZE_CORE; i++) addr[i] = 32'h1000 + 4 * i;
    drive(32'hFFFF_FFFF, 1'b1, 1'b0, 3'd1, 2'd0);
    collect(1, 3, 20);
    checks++;
    if (hold_viol != 0 || n_stall != 5) begin
      errors++;
      $display("FAIL bp_hold: changes %0d stall %0d expected 0 and 5", hold_viol, n_stall);
    end
    checks++;
    if (!got_done || done_cyc != 5 || got_line.size() != 2 || got_line[0] !== 32'h40 ||
        got_mask[0] !== 32'h0000_FFFF || got_mask[1] !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL bp_reqs: done %b at %0d n %0d first %h/%h expected 1 at 5 n 2 40/0000ffff",
               got_done, done_cyc, got_line.size(), got_line[0], got_mask[0]);
    end
  endtask
  task automatic test_zero_mask();
    drive(32'h0, 1'b1, 1'b0, 3'd6, 2'd2);
    collect(0, 0, 5);
    checks++;
    if (!got_done || done_cyc != 0 || n_stall != 0 || got_line.size() != 0 || got_dwarp !== 3'd6) begin
      errors++;
      $display("FAIL zero_mask: done %b at %0d stall %0d reqs %0d warp %0d expected 1 at 0 stall 0 reqs 0 warp 6",
               got_done, done_cyc, n_stall, got_line.size(), got_dwarp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse: done %b stall %b expected 0 0", done_o, stall_o);
    end
  endtask
  task automatic test_inactive();
    for (int i = 0; i < SIZE_CORE; i++) addr[i] = $urandom();
    addr[0] = 32'h2000;
    addr[1] = 32'h2008;
    addr[2] = 32'h2010;
    drive(32'h5, 1'b1, 1'b0, 3'd3, 2'd1);
    collect(0, 0, 20);
    checks++;
    if (got_line.size() != 1 || got_line[0] !== 32'h80 || got_mask[0] !== 32'h5 || !got_done) begin
      errors++;
      $display("FAIL inactive: got n=%0d %h/%h expected 1 request 80/00000005", got_line.size(), got_line[0], got_mask[0]);
    end
  endtask
  task automatic test_neither();
    for (int i = 0; i < SIZE_CORE; i++) addr[i] = 64 * i;
    drive(32'hFF, 1'b0, 1'b0, 3'd4, 2'd0);
    collect(0, 0, 6);
    checks++;
    if (got_done || got_line.size() != 0 || n_stall != 0) begin
      errors++;
      $display("FAIL neither: done %b reqs %0d stall %0d expected 0 0 0", got_done, got_line.size(), n_stall);
    end
  endtask
  task automatic test_both();
    for (int i = 0; i < SIZE_CORE; i++) addr[i] = 64 * i;
    drive(32'h3, 1'b1, 1'b1, 3'd7, 2'd2);
    collect(0, 0, 20);
    checks++;
    if (got_load !== 1'b1 || got_store !== 1'b0 || got_line.size() != 2 || !got_done) begin
      errors++;
      $display("FAIL both_types: ld %b st %b reqs %0d expected 1 0 2", got_load, got_store, got_line.size());
    end
  endtask
  task automatic test_async_reset();
    int nv;
    for (int i = 0; i < SIZE_CORE; i++) addr[i] = 32'h1000 + 4 * i;
    drive(32'hFFFF_FFFF, 1'b1, 1'b1, 3'd2, 2'd3);
    req_ready_i = 1'b1;
    @(posedge clk);
    #1;
    req_ready_i = 1'b0;
    checks++;
    if (req_mask_o !== 32'hFFFF_0000 || stall_o !== 1'b1) begin
      errors++;
      $display("FAIL ar_pending: mask %h stall %b expected ffff0000 1", req_mask_o, stall_o);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({stall_o, req_valid_o, done_o, req_load_o, req_store_o} !== 5'b0 || req_mask_o !== '0 ||
        req_line_o !== '0 || packets_o !== '0 || req_warp_o !== '0 || req_space_o !== '0) begin
      errors++;
      $display("FAIL ar_clear: ctrl %b mask %h line %h expected all 0",
               {stall_o, req_valid_o, done_o, req_load_o, req_store_o}, req_mask_o, req_line_o);
    end
    #2;
    reset = 1'b1;
    req_ready_i = 1'b1;
    nv = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (req_valid_o || stall_o || done_o) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL ar_idle: got %0d active cycles expected 0", nv);
    end
  endtask
  task automatic test_random();
    logic [31:0] m, base;
    logic [1:0] t;
    logic [NUM_WARP_LOG-1:0] w;
    for (int n = 0; n < 40; n++) begin
      base = $urandom() & 32'hFFFF_F000;
      for (int i = 0; i < SIZE_CORE; i++) addr[i] = base + $urandom_range(0, 511);
      case ($urandom_range(0, 3))
        0: m = 32'hFFFF_FFFF;
        1: m = $urandom();
        2: m = $urandom() & $urandom() & $urandom();
        default: m = 32'h1 << $urandom_range(0, 31);
      endcase
      t = 2'($urandom_range(1, 3));
      w = NUM_WARP_LOG'($urandom());
      build_model(m);
      drive(m, t[0], t[1], w, LDST_SPACE_LOG'($urandom()));
      collect(2, 0, 600);
      checks++;
      if (!got_done || got_dwarp !== w || got_line.size() != exp_line.size() || hold_viol != 0) begin
        errors++;
        $display("FAIL rand%0d_done: done %b warp %0d reqs %0d holdchg %0d expected 1 %0d %0d 0",
                 n, got_done, got_dwarp, got_line.size(), hold_viol, w, exp_line.size());
      end
      for (int k = 0; k < exp_line.size(); k++) begin
        checks++;
        if (got_line[k] !== exp_line[k] || got_mask[k] !== exp_mask[k]) begin
          errors++;
          $display("FAIL rand%0d_req%0d: got %h/%h expected %h/%h", n, k, got_line[k], got_mask[k], exp_line[k], exp_mask[k]);
        end
      end
      if (m != 0) begin
        checks++;
        if (first_valid != 0 || got_load !== t[0] || got_store !== (t[1] & ~t[0])) begin
          errors++;
          $display("FAIL rand%0d_attr: first %0d ld %b st %b expected 0 %b %b", n, first_valid, got_load, got_store, t[0], t[1] & ~t[0]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_full_warp();
    test_stride();
    test_backpressure();
    test_zero_mask();
    test_inactive();
    test_neither();
    test_both();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
